// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - LR35902 instruction fetch: assembles opcode, CB prefix and immediates, owns the PC
module instr_fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_req,
    input  logic        pc_load,
    input  logic [15:0] pc_in,
    output logic [15:0] mem_addr,
    output logic        mem_rd_en,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [7:0]  op_code,
    output logic        prefix_cb,
    output logic [15:0] imm,
    output logic [1:0]  instr_len,
    output logic [15:0] instr_pc,
    output logic [15:0] pc
);

    typedef enum logic [2:0] {
        S_IDLE, S_OP, S_CB, S_IMM_LO, S_IMM_HI, S_DONE, S_FLUSH
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] pending;
    logic        reading;

    function automatic logic [1:0] opcode_len(input logic [7:0] b);
        case (b)
            8'h06, 8'h0E, 8'h16, 8'h1E, 8'h26, 8'h2E, 8'h36, 8'h3E,
            8'h10, 8'h18, 8'h20, 8'h28, 8'h30, 8'h38,
            8'hC6, 8'hCE, 8'hD6, 8'hDE, 8'hE6, 8'hEE, 8'hF6, 8'hFE,
            8'hE0, 8'hF0, 8'hE8, 8'hF8:                       opcode_len = 2'd2;
            8'h01, 8'h11, 8'h21, 8'h31, 8'h08,
            8'hC2, 8'hC3, 8'hCA, 8'hD2, 8'hDA,
            8'hC4, 8'hCC, 8'hCD, 8'hD4, 8'hDC, 8'hEA, 8'hFA: opcode_len = 2'd3;
            default:                                          opcode_len = 2'd1;
        endcase
    endfunction

    assign reading     = (state == S_OP) || (state == S_CB) ||
                         (state == S_IMM_LO) || (state == S_IMM_HI);
    assign mem_rd_en   = reading || (state == S_FLUSH);
    // pc does not advance until the ack, so it doubles as the held bus address
    assign mem_addr    = mem_rd_en ? pc : 16'h0000;
    assign instr_valid = (state == S_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (!pc_load && fetch_req) state_nxt = S_OP;
            S_OP:     if (mem_ack) begin
                          if (mem_rdata == 8'hCB)                 state_nxt = S_CB;
                          else if (opcode_len(mem_rdata) == 2'd1) state_nxt = S_DONE;
                          else                                    state_nxt = S_IMM_LO;
                      end
            S_CB:     if (mem_ack) state_nxt = S_DONE;
            S_IMM_LO: if (mem_ack) state_nxt = (opcode_len(op_code) == 2'd3) ? S_IMM_HI : S_DONE;
            S_IMM_HI: if (mem_ack) state_nxt = S_DONE;
            S_DONE:   if (pc_load || instr_ready) state_nxt = S_IDLE;
            S_FLUSH:  if (mem_ack) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
        // A redirect mid-read must still drain the outstanding bus cycle
        if (reading && pc_load) state_nxt = mem_ack ? S_IDLE : S_FLUSH;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc        <= RESET_PC;
            pending   <= 16'h0000;
            op_code   <= 8'h00;
            prefix_cb <= 1'b0;
            imm       <= 16'h0000;
            instr_len <= 2'd0;
            instr_pc  <= 16'h0000;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pc_load) begin
                        pc <= pc_in;
                    end else if (fetch_req) begin
                        instr_pc  <= pc;
                        op_code   <= 8'h00;
                        prefix_cb <= 1'b0;
                        imm       <= 16'h0000;
                        instr_len <= 2'd0;
                    end
                end
                S_DONE: if (pc_load) pc <= pc_in;
                S_FLUSH: begin
                    if (pc_load) begin
                        if (mem_ack) pc <= pc_in;
                        else         pending <= pc_in;
                    end else if (mem_ack) begin
                        pc <= pending;
                    end
                end
                default: begin
                    if (pc_load) begin
                        if (mem_ack) pc <= pc_in;
                        else         pending <= pc_in;
                    end else if (mem_ack) begin
                        pc        <= pc + 16'd1;
                        instr_len <= instr_len + 2'd1;
                        case (state)
                            S_OP: begin
                                if (mem_rdata == 8'hCB) prefix_cb <= 1'b1;
                                else                    op_code   <= mem_rdata;
                            end
                            S_CB:     op_code    <= mem_rdata;
                            S_IMM_LO: imm[7:0]   <= mem_rdata;
                            S_IMM_HI: imm[15:8]  <= mem_rdata;
                            default:  ;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - self-checking bench for instr_fetch_unit with bus responder and reference model
module tb_instr_fetch_unit;

    logic        clk, rst, fetch_req, pc_load, mem_rd_en, mem_ack, instr_valid, instr_ready, prefix_cb;
    logic [15:0] pc_in, mem_addr, imm, instr_pc, pc;
    logic [7:0]  mem_rdata, op_code;
    logic [1:0]  instr_len;

    instr_fetch_unit #(.RESET_PC(16'h0000)) dut (
        .clk(clk), .rst(rst), .fetch_req(fetch_req), .pc_load(pc_load), .pc_in(pc_in),
        .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .op_code(op_code),
        .prefix_cb(prefix_cb), .imm(imm), .instr_len(instr_len), .instr_pc(instr_pc), .pc(pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int lat = 0;
    int wcnt = 0;
    int rd_count = 0;
    logic [7:0] mem [65536];

    logic [7:0] two_tbl [26] = '{8'h06, 8'h0E, 8'h16, 8'h1E, 8'h26, 8'h2E, 8'h36, 8'h3E,
                                 8'h10, 8'h18, 8'h20, 8'h28, 8'h30, 8'h38, 8'hC6, 8'hCE,
                                 8'hD6, 8'hDE, 8'hE6, 8'hEE, 8'hF6, 8'hFE, 8'hE0, 8'hF0,
                                 8'hE8, 8'hF8};
    logic [7:0] three_tbl [17] = '{8'h01, 8'h11, 8'h21, 8'h31, 8'h08, 8'hC2, 8'hC3, 8'hCA,
                                   8'hD2, 8'hDA, 8'hC4, 8'hCC, 8'hCD, 8'hD4, 8'hDC, 8'hEA,
                                   8'hFA};

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  b0, b1, b2;
        logic [7:0]  op;
        logic        cb;
        logic [15:0] imm;
        logic [1:0]  len;
        logic [15:0] npc;
    } vec_t;
    vec_t vecs[9];

    // Bus slave: acks each read after lat idle cycles
    initial begin
        mem_ack = 1'b0;
        mem_rdata = 8'h00;
        forever begin
            @(posedge clk); #1;
            mem_ack = 1'b0;
            if (!rst && mem_rd_en) begin
                if (wcnt >= lat) begin
                    mem_ack = 1'b1;
                    mem_rdata = mem[mem_addr];
                    wcnt = 0;
                    rd_count++;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", nm, act, exp);
        end
    endtask

    function automatic int ref_len(input logic [7:0] b);
        foreach (two_tbl[i]) if (two_tbl[i] == b) return 2;
        foreach (three_tbl[i]) if (three_tbl[i] == b) return 3;
        return 1;
    endfunction

    task automatic model(input logic [15:0] a, output logic [7:0] op, output logic cb,
                         output logic [15:0] im, output logic [1:0] len);
        logic [15:0] a1, a2;
        int n;
        a1 = a + 16'd1;
        a2 = a + 16'd2;
        if (mem[a] == 8'hCB) begin
            op = mem[a1]; cb = 1'b1; im = 16'h0000; len = 2'd2;
        end else begin
            n = ref_len(mem[a]);
            op = mem[a]; cb = 1'b0; len = n[1:0];
            if (n == 1)      im = 16'h0000;
            else if (n == 2) im = {8'h00, mem[a1]};
            else             im = {mem[a2], mem[a1]};
        end
    endtask

    task automatic put3(input logic [15:0] a, input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        logic [15:0] a1, a2;
        a1 = a + 16'd1;
        a2 = a + 16'd2;
        mem[a] = b0; mem[a1] = b1; mem[a2] = b2;
    endtask

    task automatic load_pc(input logic [15:0] a);
        pc_load = 1'b1; pc_in = a;
        step();
        pc_load = 1'b0;
        chk("load_pc", pc, a);
    endtask

    task automatic do_fetch();
        bit ok;
        ok = 0;
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (instr_valid) begin ok = 1; break; end
            step();
        end
        chk("fetch_timeout", {31'd0, ok}, 32'd1);
    endtask

    task automatic accept();
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        chk("valid_drop", {31'd0, instr_valid}, 32'd0);
        chk("no_refetch", {31'd0, mem_rd_en}, 32'd0);
    endtask

    initial begin
        logic [7:0]  e_op;
        logic        e_cb;
        logic [15:0] e_imm, a;
        logic [1:0]  e_len;
        int r0, k;
        bit seen;

        rst = 1'b1; fetch_req = 1'b0; pc_load = 1'b0; pc_in = 16'h0000; instr_ready = 1'b0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        vecs[0] = '{16'h0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 16'h0000, 2'd1, 16'h0001};
        vecs[1] = '{16'h0100, 8'h01, 8'h34, 8'h12, 8'h01, 1'b0, 16'h1234, 2'd3, 16'h0103};
        vecs[2] = '{16'h0200, 8'hCB, 8'h37, 8'h00, 8'h37, 1'b1, 16'h0000, 2'd2, 16'h0202};
        vecs[3] = '{16'hFFFF, 8'h3E, 8'h42, 8'h00, 8'h3E, 1'b0, 16'h0042, 2'd2, 16'h0001};
        vecs[4] = '{16'h0300, 8'hD3, 8'h55, 8'h66, 8'hD3, 1'b0, 16'h0000, 2'd1, 16'h0301};
        vecs[5] = '{16'h0400, 8'hE0, 8'h80, 8'h99, 8'hE0, 1'b0, 16'h0080, 2'd2, 16'h0402};
        vecs[6] = '{16'h0500, 8'hCD, 8'h00, 8'hC0, 8'hCD, 1'b0, 16'hC000, 2'd3, 16'h0503};
        vecs[7] = '{16'h0600, 8'hCB, 8'hFE, 8'h11, 8'hFE, 1'b1, 16'h0000, 2'd2, 16'h0602};
        vecs[8] = '{16'hFFFE, 8'h21, 8'hAD, 8'hDE, 8'h21, 1'b0, 16'hDEAD, 2'd3, 16'h0001};

        step(); step();
        chk("rst_pc", pc, 16'h0000);
        chk("rst_addr", mem_addr, 16'h0000);
        chk("rst_rd_en", {31'd0, mem_rd_en}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_bundle", {op_code, imm, instr_len, prefix_cb}, 32'd0);
        chk("rst_instr_pc", instr_pc, 16'h0000);
        rst = 1'b0;
        step();

        // first fetch straight out of reset
        lat = 1;
        do_fetch();
        chk("boot_bundle", {op_code, prefix_cb, imm, instr_len}, {8'h00, 1'b0, 16'h0000, 2'd1});
        chk("boot_pcs", {instr_pc, pc}, {16'h0000, 16'h0001});
        accept();

        foreach (vecs[i]) begin
            put3(vecs[i].addr, vecs[i].b0, vecs[i].b1, vecs[i].b2);
            lat = i % 3;
            load_pc(vecs[i].addr);
            r0 = rd_count;
            do_fetch();
            chk($sformatf("vec%0d_op", i), op_code, vecs[i].op);
            chk($sformatf("vec%0d_cb", i), prefix_cb, vecs[i].cb);
            chk($sformatf("vec%0d_imm", i), imm, vecs[i].imm);
            chk($sformatf("vec%0d_len", i), instr_len, vecs[i].len);
            chk($sformatf("vec%0d_ipc", i), instr_pc, vecs[i].addr);
            chk($sformatf("vec%0d_pc", i), pc, vecs[i].npc);
            chk($sformatf("vec%0d_reads", i), rd_count - r0, vecs[i].len);
            accept();
        end

        // redirect during the low-immediate read of a JP with slow acks
        put3(16'h0700, 8'hC3, 8'h00, 8'h40);
        mem[16'h0150] = 8'h00;
        load_pc(16'h0700);
        lat = 3;
        fetch_req = 1'b1; step(); fetch_req = 1'b0;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            if (mem_rd_en && mem_addr == 16'h0701) begin seen = 1; break; end
            step();
        end
        chk("imm_lo_reached", {31'd0, seen}, 32'd1);
        pc_load = 1'b1; pc_in = 16'h0150;
        step();
        pc_load = 1'b0;
        k = 0;
        while (mem_rd_en && k < 20) begin
            chk("flush_addr", mem_addr, 16'h0701);
            chk("flush_valid", {31'd0, instr_valid}, 32'd0);
            step();
            k++;
        end
        chk("flush_drained", {31'd0, mem_rd_en}, 32'd0);
        chk("flush_pc", pc, 16'h0150);
        lat = 0;
        do_fetch();
        chk("post_flush_ipc", instr_pc, 16'h0150);
        chk("post_flush_pc", pc, 16'h0151);
        accept();

        // redirect coinciding with the opcode ack
        put3(16'h0800, 8'hC3, 8'h11, 8'h22);
        load_pc(16'h0800);
        fetch_req = 1'b1; step(); fetch_req = 1'b0;
        pc_load = 1'b1; pc_in = 16'h0900;
        step();
        pc_load = 1'b0;
        chk("coincide_pc", pc, 16'h0900);
        chk("coincide_rd", {31'd0, mem_rd_en}, 32'd0);
        chk("coincide_valid", {31'd0, instr_valid}, 32'd0);

        // bundle held while the control path stalls
        put3(16'h0A00, 8'h18, 8'hFE, 8'h77);
        load_pc(16'h0A00);
        do_fetch();
        for (int i = 0; i < 5; i++) begin
            chk("hold_bundle", {op_code, imm, instr_len, prefix_cb}, {8'h18, 16'h00FE, 2'd2, 1'b0});
            chk("hold_valid_bus", {instr_valid, mem_rd_en}, 2'b10);
            step();
        end
        accept();

        // redirect discards a held bundle
        put3(16'h0B00, 8'h00, 8'h00, 8'h00);
        load_pc(16'h0B00);
        do_fetch();
        pc_load = 1'b1; pc_in = 16'h0C00;
        step();
        pc_load = 1'b0;
        chk("discard_valid", {31'd0, instr_valid}, 32'd0);
        chk("discard_pc", pc, 16'h0C00);

        // reset in the middle of a transaction
        put3(16'h0D00, 8'hC3, 8'h00, 8'h00);
        load_pc(16'h0D00);
        lat = 4;
        fetch_req = 1'b1; step(); fetch_req = 1'b0;
        step();
        rst = 1'b1; #1;
        chk("midrst_pc", pc, 16'h0000);
        chk("midrst_bus", {mem_rd_en, instr_valid, mem_addr}, 18'd0);
        step();
        rst = 1'b0;
        step();
        lat = 0;
        model(16'h0000, e_op, e_cb, e_imm, e_len);
        do_fetch();
        chk("midrst_refetch", {op_code, prefix_cb, imm, instr_len}, {e_op, e_cb, e_imm, e_len});
        accept();

        // randomized instructions against the reference model
        for (int it = 0; it < 40; it++) begin
            a = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       e_op = two_tbl[$urandom_range(0, 25)];
                1:       e_op = three_tbl[$urandom_range(0, 16)];
                2:       e_op = 8'hCB;
                default: e_op = 8'($urandom);
            endcase
            put3(a, e_op, 8'($urandom), 8'($urandom));
            lat = $urandom_range(0, 2);
            load_pc(a);
            model(a, e_op, e_cb, e_imm, e_len);
            r0 = rd_count;
            do_fetch();
            chk("rnd_bundle", {op_code, prefix_cb, imm, instr_len}, {e_op, e_cb, e_imm, e_len});
            chk("rnd_pcs", {instr_pc, pc}, {a, a + {14'd0, e_len}});
            chk("rnd_reads", rd_count - r0, {30'd0, e_len});
            k = $urandom_range(0, 3);
            for (int j = 0; j < k; j++) begin
                step();
                chk("rnd_hold", {instr_valid, op_code, imm}, {1'b1, e_op, e_imm});
            end
            accept();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
